// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO step controller: FSM states and parameter defaults.
package nco_ctrl_pkg;

  // Guard time after each issued step scales with the NCO ring length.
  function automatic int wait_cyc_of(input int m);
    return 2 * m + 2;
  endfunction

  localparam int M_DEF        = 24;
  localparam int CW_DEF       = 8;
  localparam int WAIT_CYC_DEF = wait_cyc_of(M_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/nco_step_acc.sv
// Saturating signed accumulator of outstanding NCO steps with sticky overflow.
// Requests add/subtract a count; each issued pulse retires one step.
module nco_step_acc
  import nco_ctrl_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 add_en_i,
  input  logic                 add_dir_i,
  input  logic [CW-2:0]        add_cnt_i,
  input  logic                 step_en_i,
  input  logic                 step_up_i,
  output logic signed [CW-1:0] pending_o,
  output logic                 ovf_o
);

  // Two guard bits so the raw sum can never wrap before it is clipped.
  localparam logic signed [CW+1:0] PMAX = (CW+2)'((1 << (CW-1)) - 1);
  localparam logic signed [CW+1:0] NMAX = -PMAX;
  localparam logic signed [CW+1:0] ONE  = (CW+2)'(1);

  logic signed [CW-1:0] pending_q, pending_d;
  logic                 ovf_q, ovf_d;
  logic signed [CW+1:0] delta, sum;

  // Next pending value: clear wins, then a request, then retiring an issued step.
  always_comb begin
    delta     = '0;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (add_en_i)
      delta = add_dir_i ? $signed({3'b000, add_cnt_i}) : -$signed({3'b000, add_cnt_i});
    else if (step_en_i)
      delta = step_up_i ? ONE : -ONE;
    sum = $signed({{2{pending_q[CW-1]}}, pending_q}) + delta;
    if (clr_i) begin
      pending_d = '0;
      ovf_d     = 1'b0;
    end else if (add_en_i || step_en_i) begin
      if (sum > PMAX) begin
        pending_d = PMAX[CW-1:0];
        ovf_d     = 1'b1;
      end else if (sum < NMAX) begin
        pending_d = NMAX[CW-1:0];
        ovf_d     = 1'b1;
      end else begin
        pending_d = sum[CW-1:0];
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending_o = pending_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/nco_step_ctrl.sv
// NCO step controller: accepts signed step requests, then meters them out as
// single advance/retard pulses separated by a guard interval.
module nco_step_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int M        = M_DEF,
  parameter int CW       = CW_DEF,
  parameter int WAIT_CYC = wait_cyc_of(M)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_valid,
  input  logic                 step_dir,
  input  logic [CW-2:0]        step_cnt,
  output logic                 step_ready,
  input  logic                 clr,
  output logic                 adv,
  output logic                 ret,
  output logic                 busy,
  output logic signed [CW-1:0] pending,
  output logic                 ovf
);

  localparam int TW = $clog2(WAIT_CYC + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          adv_q, adv_d, ret_q, ret_d;
  logic          accept;

  assign step_ready = (state_q != ISSUE) && !rst;
  assign accept     = step_valid && step_ready;
  assign busy       = (state_q != IDLE);
  assign adv        = adv_q;
  assign ret        = ret_q;

  // The retired step follows the pulse actually issued, so pending always
  // equals requested steps minus issued steps, even if a request lands on the
  // same edge that starts ISSUE.
  nco_step_acc #(.CW(CW)) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .add_en_i  (accept),
    .add_dir_i (step_dir),
    .add_cnt_i (step_cnt),
    .step_en_i (state_q == ISSUE),
    .step_up_i (ret_q),
    .pending_o (pending),
    .ovf_o     (ovf)
  );

  // Next state, guard timer and the pulse to register for the ISSUE cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    adv_d   = 1'b0;
    ret_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending != '0) begin
          state_d = ISSUE;
          adv_d   = (pending > 0);
          ret_d   = (pending < 0);
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = TW'(WAIT_CYC - 1);
      end
      WAIT: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timer and registered pulse outputs; reset aborts any step in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      adv_q   <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      adv_q   <= adv_d;
      ret_q   <= ret_d;
    end
  end

endmodule

// File: tb/tb_nco_step_ctrl.sv
// Bench for nco_step_ctrl: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nco_step_ctrl;
  localparam int M    = 24;
  localparam int CW   = 8;
  localparam int WC   = 2 * M + 2;
  localparam int PMAX = 127;

  logic clk = 1'b0;
  logic rst = 1'b1, step_valid = 1'b0, step_dir = 1'b0, clr = 1'b0;
  logic [CW-2:0] step_cnt = '0;
  logic step_ready, adv, ret, busy, ovf;
  logic signed [CW-1:0] pending;

  int errors = 0, checks = 0;
  int adv_n = 0, ret_n = 0;
  bit chk_en = 1'b0;

  // Model: outstanding = requested - issued (saturated); a pulse at cycle P
  // blocks the next one until P+WC+2; the cycle of the pulse refuses requests.
  int cyc = 0, m_last = -1000, m_pend = 0;
  bit m_ovf = 1'b0, m_adv = 1'b0, m_ret = 1'b0;

  nco_step_ctrl #(.M(M), .CW(CW)) dut (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_dir(step_dir),
    .step_cnt(step_cnt), .step_ready(step_ready), .clr(clr), .adv(adv),
    .ret(ret), .busy(busy), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    if (v > PMAX) return PMAX;
    if (v < -PMAX) return -PMAX;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit d, input int n);
    step_valid = 1'b1;
    step_dir   = d;
    step_cnt   = 7'(n);
    tick();
    step_valid = 1'b0;
    step_cnt   = '0;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(adv || ret) && n < 300);
  endtask

  // Reference model advance at each active edge.
  always @(posedge clk) begin
    bit idle, in_issue, acc, novf, nadv, nret;
    int np, raw, nlast;
    idle     = (cyc >= m_last + WC + 1);
    in_issue = (cyc == m_last);
    acc      = step_valid && !rst && !in_issue;
    np = m_pend; novf = m_ovf; nadv = 1'b0; nret = 1'b0; nlast = m_last;
    if (rst) begin
      np = 0; novf = 1'b0; nlast = -1000;
    end else begin
      if (clr) begin
        np = 0; novf = 1'b0;
      end else if (acc) begin
        raw = m_pend + (step_dir ? int'(step_cnt) : -int'(step_cnt));
        np  = sat(raw);
        if (np != raw) novf = 1'b1;
      end else if (in_issue) begin
        np = sat(m_pend + (m_adv ? -1 : 1));
      end
      if (idle && m_pend != 0) begin
        nlast = cyc + 1;
        nadv  = (m_pend > 0);
        nret  = (m_pend < 0);
      end
    end
    m_pend = np; m_ovf = novf; m_adv = nadv; m_ret = nret; m_last = nlast;
    cyc++;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (adv) adv_n++;
    if (ret) ret_n++;
    if (chk_en) begin
      chk("pending", int'(pending), m_pend);
      chk("ovf", int'(ovf), int'(m_ovf));
      chk("adv", int'(adv), int'(m_adv));
      chk("ret", int'(ret), int'(m_ret));
      chk("busy", int'(busy), int'(!(cyc >= m_last + WC + 1)));
      chk("step_ready", int'(step_ready), int'(!rst && cyc != m_last));
      if (adv && ret) chk("adv_ret_exclusive", 1, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, r0;
    rst = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_pending", int'(pending), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(step_ready), 0);
    chk("rst_adv", int'(adv), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", int'(step_ready), 1);
    tick();

    // Three advance steps: first pulse 2 cycles after accept, then every 52.
    a0 = adv_n;
    req(1'b1, 3);
    chk("s35_pend", int'(pending), 3);
    chk("s35_no_early_adv", int'(adv), 0);
    tick();
    chk("s35_first_adv", int'(adv), 1);
    wait_pulse(n);
    chk("s35_gap1", n, 52);
    chk("s35_adv2", int'(adv), 1);
    wait_pulse(n);
    chk("s35_gap2", n, 52);
    repeat (60) tick();
    chk("s35_pend_end", int'(pending), 0);
    chk("s35_adv_count", adv_n - a0, 3);
    chk("s35_idle", int'(busy), 0);

    // Advance 2, then retard 5 while waiting: 1 -> -4, four retard pulses.
    a0 = adv_n; r0 = ret_n;
    req(1'b1, 2);
    tick();
    chk("s36_adv", int'(adv), 1);
    repeat (5) tick();
    chk("s36_pend1", int'(pending), 1);
    chk("s36_busy", int'(busy), 1);
    req(1'b0, 5);
    chk("s36_pend2", int'(pending), -4);
    repeat (4 * 52 + 60) tick();
    chk("s36_adv_count", adv_n - a0, 1);
    chk("s36_ret_count", ret_n - r0, 4);
    chk("s36_pend_end", int'(pending), 0);

    // Saturation and clear.
    req(1'b1, 127);
    chk("s37_pend127", int'(pending), 127);
    chk("s37_ovf0", int'(ovf), 0);
    req(1'b1, 10);
    chk("s37_pend_sat", int'(pending), 127);
    chk("s37_ovf1", int'(ovf), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s37_clr_pend", int'(pending), 0);
    chk("s37_clr_ovf", int'(ovf), 0);
    repeat (60) tick();
    chk("s37_idle", int'(busy), 0);

    // Request held through ISSUE is refused there and accepted a cycle later.
    req(1'b1, 1);
    tick();
    chk("s38_adv", int'(adv), 1);
    step_valid = 1'b1; step_dir = 1'b1; step_cnt = 7'd2;
    #1;
    chk("s38_ready_issue", int'(step_ready), 0);
    tick();
    chk("s38_no_accept", int'(pending), 0);
    chk("s38_ready_wait", int'(step_ready), 1);
    tick();
    step_valid = 1'b0; step_cnt = '0;
    chk("s38_accept_next", int'(pending), 2);
    repeat (170) tick();
    chk("s38_pend_end", int'(pending), 0);

    // Reset 10 cycles into WAIT with 2 steps still pending.
    a0 = adv_n;
    req(1'b1, 3);
    repeat (12) tick();
    chk("s39_pend", int'(pending), 2);
    chk("s39_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk("s39_rst_busy", int'(busy), 0);
    chk("s39_rst_pend", int'(pending), 0);
    rst = 1'b0;
    repeat (120) tick();
    chk("s39_no_more_adv", adv_n - a0, 1);

    // Clear and accept on the same edge: request dropped.
    a0 = adv_n;
    step_valid = 1'b1; step_dir = 1'b1; step_cnt = 7'd5; clr = 1'b1;
    tick();
    step_valid = 1'b0; clr = 1'b0; step_cnt = '0;
    chk("s40_pend", int'(pending), 0);
    repeat (5) tick();
    chk("s40_idle", int'(busy), 0);
    chk("s40_no_adv", adv_n - a0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step_valid = ($urandom_range(0, 7) == 0);
      step_dir   = 1'($urandom_range(0, 1));
      step_cnt   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                               : 7'($urandom_range(0, 3));
      clr        = ($urandom_range(0, 99) == 0);
      rst        = ($urandom_range(0, 799) == 0);
      tick();
    end
    step_valid = 1'b0; clr = 1'b0; rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
